// File: rtl/firebird7_in_gate2_ijtag_pkg.sv
// Shared constants for the gate2 IJTAG segment-insertion network.
package firebird7_in_gate2_ijtag_pkg;
   localparam int CAP_ZERO        = 0;
   localparam int CAP_STATUS      = 1;
   localparam int DEFAULT_NUM_SIB = 4;
endpackage

// File: rtl/firebird7_in_gate2_tessent_sib_cell.sv
// One segment-insertion bit: shift/capture register, update latch, optional select delay
// and the host-bypass source mux.
module firebird7_in_gate2_tessent_sib_cell
   import firebird7_in_gate2_ijtag_pkg::*;
#(
   parameter int CAPTURE_STATUS = CAP_ZERO,
   parameter bit DELAYED_SEL    = 1'b1
) (
   input  logic tck_i,
   input  logic rst_ni,
   input  logic sel_i,
   input  logic ce_i,
   input  logic se_i,
   input  logic ue_i,
   input  logic chain_i,
   input  logic from_so_i,
   output logic sib_o,
   output logic latch_o,
   output logic enable_o
);
   logic sib_q, sib_d;
   logic latch_q, latch_d;

   // An open host is spliced in front of this bit, so the bit shifts from the host's SO.
   always_comb begin
      sib_d = sib_q;
      if (sel_i && ce_i) begin
         sib_d = (CAPTURE_STATUS == CAP_STATUS) ? latch_q : 1'b0;
      end else if (sel_i && se_i) begin
         sib_d = latch_q ? from_so_i : chain_i;
      end
   end

   always_ff @(posedge tck_i or negedge rst_ni) begin
      if (!rst_ni) sib_q <= 1'b0;
      else         sib_q <= sib_d;
   end

   always_comb begin
      latch_d = latch_q;
      if (sel_i && ue_i) latch_d = sib_q;
   end

   always_ff @(negedge tck_i or negedge rst_ni) begin
      if (!rst_ni) latch_q <= 1'b0;
      else         latch_q <= latch_d;
   end

   if (DELAYED_SEL) begin : g_delay
      logic enable_q;
      always_ff @(negedge tck_i or negedge rst_ni) begin
         if (!rst_ni) enable_q <= 1'b0;
         else         enable_q <= latch_q;
      end
      assign enable_o = enable_q;
   end else begin : g_direct
      assign enable_o = latch_q;
   end

   assign sib_o   = sib_q;
   assign latch_o = latch_q;
endmodule

// File: rtl/firebird7_in_gate2_tessent_sib_multi.sv
// Chain of NUM_SIB segment-insertion bits in one IJTAG segment, each gating one host
// sub-network; holds the chain wiring and the optional SO retiming latch.
module firebird7_in_gate2_tessent_sib_multi
   import firebird7_in_gate2_ijtag_pkg::*;
#(
   parameter int NUM_SIB        = DEFAULT_NUM_SIB,
   parameter int CAPTURE_STATUS = CAP_ZERO,
   parameter bit DELAYED_SEL    = 1'b1,
   parameter bit RETIME_SO      = 1'b1
) (
   input  logic               ijtag_tck,
   input  logic               ijtag_reset,
   input  logic               ijtag_sel,
   input  logic               ijtag_si,
   input  logic               ijtag_ce,
   input  logic               ijtag_se,
   input  logic               ijtag_ue,
   output logic               ijtag_so,
   input  logic [NUM_SIB-1:0] ijtag_from_so,
   output logic [NUM_SIB-1:0] ijtag_to_si,
   output logic [NUM_SIB-1:0] ijtag_to_sel,
   output logic [NUM_SIB-1:0] sib_open
);
   logic [NUM_SIB-1:0] sib_vec;
   logic [NUM_SIB-1:0] latch_vec;
   logic [NUM_SIB-1:0] enable_vec;

   for (genvar i = 0; i < NUM_SIB; i++) begin : g_bit
      if (i == 0) begin : g_head
         assign ijtag_to_si[i] = ijtag_si;
      end else begin : g_link
         assign ijtag_to_si[i] = sib_vec[i-1];
      end

      firebird7_in_gate2_tessent_sib_cell #(
         .CAPTURE_STATUS (CAPTURE_STATUS),
         .DELAYED_SEL    (DELAYED_SEL)
      ) u_cell (
         .tck_i     (ijtag_tck),
         .rst_ni    (ijtag_reset),
         .sel_i     (ijtag_sel),
         .ce_i      (ijtag_ce),
         .se_i      (ijtag_se),
         .ue_i      (ijtag_ue),
         .chain_i   (ijtag_to_si[i]),
         .from_so_i (ijtag_from_so[i]),
         .sib_o     (sib_vec[i]),
         .latch_o   (latch_vec[i]),
         .enable_o  (enable_vec[i])
      );
   end

   assign ijtag_to_sel = enable_vec & {NUM_SIB{ijtag_sel}};
   assign sib_open     = latch_vec;

   // Retiming holds SO stable across the high phase so the next segment samples it safely.
   if (RETIME_SO) begin : g_retime
      logic so_q;
      always_latch begin
         if (!ijtag_reset)    so_q <= 1'b0;
         else if (!ijtag_tck) so_q <= sib_vec[NUM_SIB-1];
      end
      assign ijtag_so = so_q;
   end else begin : g_direct
      assign ijtag_so = sib_vec[NUM_SIB-1];
   end
endmodule

// File: tb/tb_firebird7_in_gate2_tessent_sib_multi.sv
// Self-checking bench: default-configured DUT with host stubs, plus a capture-status,
// undelayed, unretimed DUT whose hosts are wired straight through.
module tb_firebird7_in_gate2_tessent_sib_multi;
   logic ijtag_tck   = 1'b0;
   logic ijtag_reset = 1'b1;
   logic ijtag_sel   = 1'b0;
   logic ijtag_si    = 1'b0;
   logic ijtag_ce    = 1'b0;
   logic ijtag_se    = 1'b0;
   logic ijtag_ue    = 1'b0;

   logic       so0, so1;
   logic [3:0] fromSo0, toSi0, toSel0, sibOpen0;
   logic [3:0] toSi1, toSel1, sibOpen1;

   int checks = 0;
   int errors = 0;

   int         hostLen [4] = '{2, 5, 3, 1};
   logic [7:0] hostReg [4] = '{default: 8'h00};

   bit         mHost [4][8];
   logic [3:0] mSib, mLatch, mEnable, m1Sib, m1Latch;

   always #5 ijtag_tck = ~ijtag_tck;

   firebird7_in_gate2_tessent_sib_multi dut0 (
      .ijtag_tck     (ijtag_tck),
      .ijtag_reset   (ijtag_reset),
      .ijtag_sel     (ijtag_sel),
      .ijtag_si      (ijtag_si),
      .ijtag_ce      (ijtag_ce),
      .ijtag_se      (ijtag_se),
      .ijtag_ue      (ijtag_ue),
      .ijtag_so      (so0),
      .ijtag_from_so (fromSo0),
      .ijtag_to_si   (toSi0),
      .ijtag_to_sel  (toSel0),
      .sib_open      (sibOpen0)
   );

   firebird7_in_gate2_tessent_sib_multi #(
      .NUM_SIB        (4),
      .CAPTURE_STATUS (1),
      .DELAYED_SEL    (1'b0),
      .RETIME_SO      (1'b0)
   ) dut1 (
      .ijtag_tck     (ijtag_tck),
      .ijtag_reset   (ijtag_reset),
      .ijtag_sel     (ijtag_sel),
      .ijtag_si      (ijtag_si),
      .ijtag_ce      (ijtag_ce),
      .ijtag_se      (ijtag_se),
      .ijtag_ue      (ijtag_ue),
      .ijtag_so      (so1),
      .ijtag_from_so (toSi1),
      .ijtag_to_si   (toSi1),
      .ijtag_to_sel  (toSel1),
      .sib_open      (sibOpen1)
   );

   // Host stubs for dut0: plain shift registers of hostLen bits, shifting only while selected.
   always @(posedge ijtag_tck) begin
      for (int i = 0; i < 4; i++)
         if (ijtag_se && !ijtag_ce && toSel0[i]) hostReg[i] <= {hostReg[i][6:0], toSi0[i]};
   end

   always_comb begin
      for (int i = 0; i < 4; i++) fromSo0[i] = hostReg[i][hostLen[i]-1];
   end

   task automatic modelReset();
      mSib = '0; mLatch = '0; mEnable = '0; m1Sib = '0; m1Latch = '0;
   endtask

   // Model treats the active scan path as one flat bit list: si, host0, sib0, host1, sib1, ...
   task automatic modelStep(input logic ce, input logic se, input logic ue, input logic si,
                            input logic sel);
      bit path[$];
      int idx;
      if (sel && ce) begin
         mSib  = '0;
         m1Sib = m1Latch;
      end else if (sel && se) begin
         path.push_back(si);
         for (int i = 0; i < 4; i++) begin
            if (mLatch[i]) for (int k = 0; k < hostLen[i]; k++) path.push_back(mHost[i][k]);
            path.push_back(mSib[i]);
         end
         idx = 0;
         for (int i = 0; i < 4; i++) begin
            if (mLatch[i]) for (int k = 0; k < hostLen[i]; k++) begin
               mHost[i][k] = path[idx];
               idx++;
            end
            mSib[i] = path[idx];
            idx++;
         end
         m1Sib = {m1Sib[2:0], si};
      end
      mEnable = mLatch;
      if (sel && ue) begin
         mLatch  = mSib;
         m1Latch = m1Sib;
      end
   endtask

   function automatic logic [8:0] exp0();
      return {mLatch, mEnable & {4{ijtag_sel}}, mSib[3]};
   endfunction

   function automatic logic [8:0] exp1();
      return {m1Latch, m1Latch & {4{ijtag_sel}}, m1Sib[3]};
   endfunction

   task automatic cycle(input logic ce, input logic se, input logic ue, input logic si);
      ijtag_ce = ce; ijtag_se = se; ijtag_ue = ue; ijtag_si = si;
      @(posedge ijtag_tck);
      @(negedge ijtag_tck);
      #1;
      modelStep(ce, se, ue, si, ijtag_sel);
   endtask

   task automatic measureLength(output int len);
      len = 0;
      for (int c = 0; c < 20; c++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
      for (int c = 1; c <= 40; c++) begin
         cycle(1'b0, 1'b1, 1'b0, (c == 1));
         if (so0 === 1'b1) begin
            len = c;
            break;
         end
      end
   endtask

   task automatic test_reset();
      ijtag_reset = 1'b1;
      #2 ijtag_reset = 1'b0;
      modelReset();
      #1;
      checks++;
      if ({sibOpen0, toSel0, so0, sibOpen1, toSel1, so1} !== 18'd0) begin
         errors++;
         $display("[TB] FAIL reset_initial: got %b expected all zero",
                  {sibOpen0, toSel0, so0, sibOpen1, toSel1, so1});
      end
      @(negedge ijtag_tck); #1;
      ijtag_reset = 1'b1;
      ijtag_sel   = 1'b1;
      for (int c = 0; c < 4; c++) cycle(1'b0, 1'b1, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (toSel0 !== 4'b1111) begin
         errors++;
         $display("[TB] FAIL reset_preopen: got to_sel %b expected 1111", toSel0);
      end
      // Reset lands in the high phase of a shift cycle, after the shift edge.
      ijtag_se = 1'b1; ijtag_si = 1'b1;
      @(posedge ijtag_tck);
      #2 ijtag_reset = 1'b0;
      #1;
      modelStep(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      modelReset();
      checks++;
      if ({sibOpen0, toSel0, so0, sibOpen1, toSel1, so1} !== 18'd0) begin
         errors++;
         $display("[TB] FAIL reset_midshift: got %b expected all zero",
                  {sibOpen0, toSel0, so0, sibOpen1, toSel1, so1});
      end
      ijtag_se = 1'b0;
      @(negedge ijtag_tck); #1;
      ijtag_reset = 1'b1;
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if ({sibOpen0, toSel0, so0} !== exp0() || {sibOpen1, toSel1, so1} !== exp1()) begin
         errors++;
         $display("[TB] FAIL reset_release: got %b/%b expected %b/%b",
                  {sibOpen0, toSel0, so0}, {sibOpen1, toSel1, so1}, exp0(), exp1());
      end
   endtask

   task automatic test_chain_order();
      logic [3:0] bits = 4'b0001;
      ijtag_sel = 1'b1;
      for (int c = 0; c < 4; c++) begin
         cycle(1'b0, 1'b1, 1'b0, bits[c]);
         checks++;
         if (so0 !== (c == 3) || so1 !== (c == 3) || {sibOpen0, toSel0, so0} !== exp0()) begin
            errors++;
            $display("[TB] FAIL chain_order shift %0d: got so %b/%b state %b expected so %b state %b",
                     c, so0, so1, {sibOpen0, toSel0, so0}, (c == 3), exp0());
         end
      end
   endtask

   task automatic test_open_host2();
      logic [3:0] bits = 4'b0010;
      int len, expLen;
      for (int c = 0; c < 4; c++) cycle(1'b0, 1'b1, 1'b0, bits[c]);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (sibOpen0 !== 4'b0100 || toSel0 !== 4'b0000 || toSel1 !== 4'b0100) begin
         errors++;
         $display("[TB] FAIL open_update: got open %b to_sel %b/%b expected 0100 0000/0100",
                  sibOpen0, toSel0, toSel1);
      end
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (toSel0 !== 4'b0100 || {sibOpen0, toSel0, so0} !== exp0()) begin
         errors++;
         $display("[TB] FAIL open_delayed_sel: got to_sel %b expected 0100", toSel0);
      end
      measureLength(len);
      expLen = 4;
      for (int i = 0; i < 4; i++) if (mLatch[i]) expLen += hostLen[i];
      checks++;
      if (len != expLen) begin
         errors++;
         $display("[TB] FAIL open_length: got %0d expected %0d", len, expLen);
      end
   endtask

   task automatic test_sel_low();
      logic [2:0] pat [6] = '{3'b010, 3'b001, 3'b100, 3'b011, 3'b111, 3'b110};
      ijtag_sel = 1'b0;
      for (int c = 0; c < 6; c++) begin
         cycle(pat[c][2], pat[c][1], pat[c][0], c[0]);
         checks++;
         if (toSel0 !== 4'b0000 || toSel1 !== 4'b0000 || {sibOpen0, toSel0, so0} !== exp0()
             || {sibOpen1, toSel1, so1} !== exp1()) begin
            errors++;
            $display("[TB] FAIL sel_low step %0d: got %b/%b expected %b/%b", c,
                     {sibOpen0, toSel0, so0}, {sibOpen1, toSel1, so1}, exp0(), exp1());
         end
      end
      ijtag_sel = 1'b1;
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if ({sibOpen0, toSel0, so0} !== exp0() || {sibOpen1, toSel1, so1} !== exp1()) begin
         errors++;
         $display("[TB] FAIL sel_restore: got %b/%b expected %b/%b",
                  {sibOpen0, toSel0, so0}, {sibOpen1, toSel1, so1}, exp0(), exp1());
      end
   endtask

   task automatic test_capture();
      logic [3:0] bits = 4'b0101;
      logic [3:0] readBack = 4'b1010;
      for (int c = 0; c < 4; c++) cycle(1'b0, 1'b1, 1'b0, bits[c]);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (sibOpen1 !== 4'b1010 || toSel1 !== 4'b1010) begin
         errors++;
         $display("[TB] FAIL capture_setup: got open %b to_sel %b expected 1010 1010",
                  sibOpen1, toSel1);
      end
      // Capture and shift asserted together: capture has priority.
      cycle(1'b1, 1'b1, 1'b0, 1'b1);
      checks++;
      if (so1 !== 1'b1 || so0 !== 1'b0 || {sibOpen0, toSel0, so0} !== exp0()) begin
         errors++;
         $display("[TB] FAIL capture_priority: got so %b/%b expected 0/1", so0, so1);
      end
      for (int c = 2; c >= 0; c--) begin
         cycle(1'b0, 1'b1, 1'b0, 1'b0);
         checks++;
         if (so1 !== readBack[c] || {sibOpen0, toSel0, so0} !== exp0()
             || {sibOpen1, toSel1, so1} !== exp1()) begin
            errors++;
            $display("[TB] FAIL capture_readout bit %0d: got so1 %b expected %b (dut0 %b vs %b)",
                     c, so1, readBack[c], {sibOpen0, toSel0, so0}, exp0());
         end
      end
   endtask

   task automatic test_random();
      bit   holdOff = 1'b0;
      int   op;
      logic r, r2, r3;
      for (int n = 0; n < 300; n++) begin
         op = $urandom_range(0, 5);
         r  = 1'($urandom_range(0, 1));
         r2 = 1'($urandom_range(0, 1));
         r3 = 1'($urandom_range(0, 1));
         ijtag_sel = 1'b1;
         if (holdOff) begin
            holdOff = 1'b0;
            cycle(1'b0, 1'b0, 1'b0, r);
         end else if (op <= 2) begin
            cycle(1'b0, 1'b1, 1'b0, r);
         end else if (op == 3) begin
            holdOff = 1'b1;
            cycle(1'b0, 1'b0, 1'b1, r);
         end else if (op == 4) begin
            cycle(1'b1, r2, 1'b0, r);
         end else begin
            ijtag_sel = 1'b0;
            cycle(r2, r3, 1'($urandom_range(0, 1)), r);
         end
         checks++;
         if ({sibOpen0, toSel0, so0} !== exp0() || {sibOpen1, toSel1, so1} !== exp1()) begin
            errors++;
            $display("[TB] FAIL random cycle %0d op %0d: got %b/%b expected %b/%b", n, op,
                     {sibOpen0, toSel0, so0}, {sibOpen1, toSel1, so1}, exp0(), exp1());
         end
      end
      ijtag_sel = 1'b1;
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_close_all();
      int len;
      ijtag_sel = 1'b1;
      for (int c = 0; c < 20; c++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (sibOpen0 !== 4'b0000 || toSel0 !== 4'b0000 || toSel1 !== 4'b0000
          || {sibOpen0, toSel0, so0} !== exp0()) begin
         errors++;
         $display("[TB] FAIL close_all: got open %b to_sel %b/%b expected 0000 0000/0000",
                  sibOpen0, toSel0, toSel1);
      end
      measureLength(len);
      checks++;
      if (len != 4) begin
         errors++;
         $display("[TB] FAIL close_length: got %0d expected 4", len);
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_chain_order();
      test_open_host2();
      test_sel_low();
      test_capture();
      test_random();
      test_close_all();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
